// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcodes, ALU op codes, mux codes, FSM states and control-word type for the multi-cycle MIPS controller
package mips_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam logic [2:0] ALUOP_RTYPE = 3'b100;
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b011;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REG    = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        R_WB     = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        ADDI_EX  = 4'd11,
        ANDI_EX  = 4'd12,
        IMM_WB   = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ ||
               op == OP_J || op == OP_ADDI || op == OP_ANDI;
    endfunction
endpackage

// File: rtl/mips_ctrl_out_decode.sv
// mips_ctrl_out_decode: combinational state -> control-word decode with the fetch/jr/illegal Mealy qualifiers
// Ports: state (current FSM state), opcode (IR[31:26]), mem_ready, jreg -> ctrl (full control word)
module mips_ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       jreg,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.pc_source = PCS_ALU;
            end
            DECODE: begin
                ctrl.alu_src_b  = SRCB_IMMSH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = !op_legal(opcode);
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_RTYPE;
                ctrl.pc_write  = jreg;
                ctrl.pc_source = jreg ? PCS_REG : PCS_ALU;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            MEM_ADDR, ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ANDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_AND;
            end
            MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
            end
            IMM_WB: ctrl.reg_write = 1'b1;
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM for the multi-cycle MIPS core (fetch/decode/execute/memory/writeback)
// Inputs: clk, rst (async active-high), opcode, jreg, zero, mem_ready
// Outputs: PC/memory/IR/register-file/ALU control, illegal_op, state_dbg,
//          retired_cnt when MCU_PERF_CNT_EN is defined (instruction retire counter)
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               jreg,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic               illegal_op,
`ifdef MCU_PERF_CNT_EN
    output logic [CNT_W-1:0]   retired_cnt,
`endif
    output logic [STATE_W-1:0] state_dbg
);
    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_unused_zero;

    // zero only matters to the datapath, which gates pc_write_cond with it
    assign w_unused_zero = zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            IDLE:     w_next = FETCH;
            FETCH:    w_next = mem_ready ? DECODE : FETCH;
            DECODE:   w_next = opcode == OP_RTYPE ? EXEC_R :
                               (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                               opcode == OP_BEQ  ? BRANCH :
                               opcode == OP_J    ? JUMP :
                               opcode == OP_ADDI ? ADDI_EX :
                               opcode == OP_ANDI ? ANDI_EX : FETCH;
            EXEC_R:   w_next = jreg ? FETCH : R_WB;
            MEM_ADDR: w_next = opcode == OP_LW ? MEM_RD : MEM_WR;
            MEM_RD:   w_next = mem_ready ? MEM_WB : MEM_RD;
            MEM_WR:   w_next = mem_ready ? FETCH : MEM_WR;
            ADDI_EX,
            ANDI_EX:  w_next = IMM_WB;
            default:  w_next = FETCH;
        endcase
    end

    mips_ctrl_out_decode u_decode (
        .state     (r_state),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .jreg      (jreg),
        .ctrl      (w_ctrl)
    );

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign pc_source     = w_ctrl.pc_source;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign reg_dst       = w_ctrl.reg_dst;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign illegal_op    = w_ctrl.illegal_op;
    assign state_dbg     = STATE_W'(r_state);

`ifdef MCU_PERF_CNT_EN
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    // An instruction retires on entry to FETCH, but not on the first fetch after IDLE or a dropped illegal opcode
    assign w_retire = w_next == FETCH && r_state != FETCH && r_state != IDLE && !w_ctrl.illegal_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + 1'b1;
    end

    assign retired_cnt = r_retired;
`endif
endmodule
